// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions: arbiter state and master identifiers.
package lc3b_types;

    localparam int ARB_ADDR_W = 12;
    localparam int ARB_DATA_W = 128;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_I = 2'd1,
        ARB_GRANT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_M_I = 1'b0,
        ARB_M_D = 1'b1
    } arb_master_t;

endpackage

// File: rtl/wb_port_mux.sv
// Selects one of two Wishbone master bundles onto the downstream bus;
// drives all-zero when neither master holds the grant.
module wb_port_mux #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 128
) (
    input  logic                sel_i,
    input  logic                sel_d,
    input  logic                if_cyc,
    input  logic                if_stb,
    input  logic                if_we,
    input  logic [ADDR_W-1:0]   if_adr,
    input  logic [DATA_W-1:0]   if_dat_m,
    input  logic [DATA_W/8-1:0] if_sel,
    input  logic                d_cyc,
    input  logic                d_stb,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_adr,
    input  logic [DATA_W-1:0]   d_dat_m,
    input  logic [DATA_W/8-1:0] d_sel,
    output logic                m_cyc,
    output logic                m_stb,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_adr,
    output logic [DATA_W-1:0]   m_dat_m,
    output logic [DATA_W/8-1:0] m_sel
);

    // Granted-master select; sel_i and sel_d are never both high
    always_comb begin
        if (sel_i) begin
            m_cyc   = if_cyc;
            m_stb   = if_stb;
            m_we    = if_we;
            m_adr   = if_adr;
            m_dat_m = if_dat_m;
            m_sel   = if_sel;
        end else if (sel_d) begin
            m_cyc   = d_cyc;
            m_stb   = d_stb;
            m_we    = d_we;
            m_adr   = d_adr;
            m_dat_m = d_dat_m;
            m_sel   = d_sel;
        end else begin
            m_cyc   = 1'b0;
            m_stb   = 1'b0;
            m_we    = 1'b0;
            m_adr   = {ADDR_W{1'b0}};
            m_dat_m = {DATA_W{1'b0}};
            m_sel   = {(DATA_W/8){1'b0}};
        end
    end

endmodule

// File: rtl/wishbone_arbiter.sv
// Two-to-one round-robin Wishbone arbiter: ifetch and data masters share
// one downstream memory port, one transfer at a time.
module wishbone_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_cyc,
    input  logic                if_stb,
    input  logic                if_we,
    input  logic [ADDR_W-1:0]   if_adr,
    input  logic [DATA_W-1:0]   if_dat_m,
    input  logic [DATA_W/8-1:0] if_sel,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_dat_s,
    input  logic                d_cyc,
    input  logic                d_stb,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_adr,
    input  logic [DATA_W-1:0]   d_dat_m,
    input  logic [DATA_W/8-1:0] d_sel,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_dat_s,
    output logic                m_cyc,
    output logic                m_stb,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_adr,
    output logic [DATA_W-1:0]   m_dat_m,
    output logic [DATA_W/8-1:0] m_sel,
    input  logic                m_ack,
    input  logic [DATA_W-1:0]   m_dat_s
);

    arb_state_t  state_r;
    arb_master_t last_r;
    logic        req_i_s;
    logic        req_d_s;
    logic        grant_i_s;
    logic        grant_d_s;

    assign req_i_s   = if_cyc & if_stb;
    assign req_d_s   = d_cyc & d_stb;
    assign grant_i_s = (state_r == ARB_GRANT_I);
    assign grant_d_s = (state_r == ARB_GRANT_D);

    // Arbitration FSM and round-robin history; m_ack only matters while granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ARB_IDLE;
            last_r  <= ARB_M_D;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (req_i_s && (!req_d_s || (last_r == ARB_M_D))) begin
                        state_r <= ARB_GRANT_I;
                    end else if (req_d_s) begin
                        state_r <= ARB_GRANT_D;
                    end else begin
                        state_r <= ARB_IDLE;
                    end
                end
                ARB_GRANT_I: begin
                    if (m_ack) begin
                        state_r <= ARB_IDLE;
                        last_r  <= ARB_M_I;
                    end else if (!req_i_s) begin
                        state_r <= ARB_IDLE;
                    end else begin
                        state_r <= ARB_GRANT_I;
                    end
                end
                ARB_GRANT_D: begin
                    if (m_ack) begin
                        state_r <= ARB_IDLE;
                        last_r  <= ARB_M_D;
                    end else if (!req_d_s) begin
                        state_r <= ARB_IDLE;
                    end else begin
                        state_r <= ARB_GRANT_D;
                    end
                end
                default: begin
                    state_r <= ARB_IDLE;
                end
            endcase
        end
    end

    // Acks go only to the granted master; read data is broadcast
    assign if_ack   = grant_i_s & m_ack;
    assign d_ack    = grant_d_s & m_ack;
    assign if_dat_s = m_dat_s;
    assign d_dat_s  = m_dat_s;

    wb_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_port_mux (
        .sel_i    (grant_i_s),
        .sel_d    (grant_d_s),
        .if_cyc   (if_cyc),
        .if_stb   (if_stb),
        .if_we    (if_we),
        .if_adr   (if_adr),
        .if_dat_m (if_dat_m),
        .if_sel   (if_sel),
        .d_cyc    (d_cyc),
        .d_stb    (d_stb),
        .d_we     (d_we),
        .d_adr    (d_adr),
        .d_dat_m  (d_dat_m),
        .d_sel    (d_sel),
        .m_cyc    (m_cyc),
        .m_stb    (m_stb),
        .m_we     (m_we),
        .m_adr    (m_adr),
        .m_dat_m  (m_dat_m),
        .m_sel    (m_sel)
    );

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed bench for wishbone_arbiter: grant order, ack routing, abort,
// spurious ack and mid-transfer reset.
module tb_wishbone_arbiter;

    logic         clk;
    logic         rst_n;
    logic         if_cyc, if_stb, if_we;
    logic [11:0]  if_adr;
    logic [127:0] if_dat_m;
    logic [15:0]  if_sel;
    logic         if_ack;
    logic [127:0] if_dat_s;
    logic         d_cyc, d_stb, d_we;
    logic [11:0]  d_adr;
    logic [127:0] d_dat_m;
    logic [15:0]  d_sel;
    logic         d_ack;
    logic [127:0] d_dat_s;
    logic         m_cyc, m_stb, m_we;
    logic [11:0]  m_adr;
    logic [127:0] m_dat_m;
    logic [15:0]  m_sel;
    logic         m_ack;
    logic [127:0] m_dat_s;

    int n_cmp = 0;
    int n_err = 0;
    int if_ack_cnt = 0;
    int d_ack_cnt = 0;
    int xfers;
    logic next_is_d;

    wishbone_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_cyc(if_cyc), .if_stb(if_stb), .if_we(if_we), .if_adr(if_adr),
        .if_dat_m(if_dat_m), .if_sel(if_sel), .if_ack(if_ack), .if_dat_s(if_dat_s),
        .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_adr(d_adr),
        .d_dat_m(d_dat_m), .d_sel(d_sel), .d_ack(d_ack), .d_dat_s(d_dat_s),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_dat_m(m_dat_m), .m_sel(m_sel), .m_ack(m_ack), .m_dat_s(m_dat_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (if_ack) if_ack_cnt <= if_ack_cnt + 1;
        if (d_ack)  d_ack_cnt  <= d_ack_cnt + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_i(input logic req, input logic [11:0] adr);
        if_cyc = req; if_stb = req; if_we = 1'b0; if_adr = adr;
        if_sel = 16'hFFFF; if_dat_m = 128'h0;
    endtask

    task automatic set_d(input logic req, input logic we, input logic [11:0] adr,
                         input logic [127:0] dat);
        d_cyc = req; d_stb = req; d_we = we; d_adr = adr;
        d_sel = 16'hFFFF; d_dat_m = dat;
    endtask

    initial begin
        rst_n = 1'b0;
        m_ack = 1'b0;
        m_dat_s = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        set_i(1'b0, 12'h000);
        set_d(1'b0, 1'b0, 12'h000, 128'h0);
        #2;
        // Reset state
        chk("rst_m_cyc", m_cyc, 1'b0);
        chk("rst_m_stb", m_stb, 1'b0);
        chk("rst_if_ack", if_ack, 1'b0);
        chk("rst_d_ack", d_ack, 1'b0);
        chk("rst_if_dat_s", if_dat_s, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
        chk("rst_d_dat_s", d_dat_s, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);

        // Single ifetch read, ack after 3 cycles
        @(negedge clk);
        rst_n = 1'b1;
        set_i(1'b1, 12'h010);
        @(negedge clk);
        chk("t1_m_cyc", m_cyc, 1'b1);
        chk("t1_m_stb", m_stb, 1'b1);
        chk("t1_m_adr", m_adr, 12'h010);
        chk("t1_m_we", m_we, 1'b0);
        chk("t1_if_ack_early", if_ack, 1'b0);
        @(negedge clk);
        @(negedge clk);
        m_ack = 1'b1;
        m_dat_s = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
        #1;
        chk("t1_if_ack", if_ack, 1'b1);
        chk("t1_d_ack", d_ack, 1'b0);
        chk("t1_if_dat_s", if_dat_s, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF);
        @(negedge clk);
        m_ack = 1'b0;
        chk("t1_idle_m_cyc", m_cyc, 1'b0);
        chk("t1_idle_m_adr", m_adr, 12'h000);
        set_i(1'b0, 12'h000);
        chk("t1_if_ack_cnt", if_ack_cnt, 1);
        chk("t1_d_ack_cnt", d_ack_cnt, 0);

        // Simultaneous request after reset: I first, D one idle cycle after
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        set_i(1'b1, 12'h030);
        set_d(1'b1, 1'b1, 12'h020, 128'hA5A5_0001_0002_0003_0004_0005_0006_5A5A);
        @(negedge clk);
        chk("t2_i_m_adr", m_adr, 12'h030);
        chk("t2_i_m_we", m_we, 1'b0);
        m_ack = 1'b1;
        #1;
        chk("t2_i_if_ack", if_ack, 1'b1);
        chk("t2_i_d_ack", d_ack, 1'b0);
        @(negedge clk);
        m_ack = 1'b0;
        set_i(1'b0, 12'h000);
        chk("t2_gap_m_cyc", m_cyc, 1'b0);
        @(negedge clk);
        chk("t2_d_m_cyc", m_cyc, 1'b1);
        chk("t2_d_m_adr", m_adr, 12'h020);
        chk("t2_d_m_we", m_we, 1'b1);
        chk("t2_d_m_sel", m_sel, 16'hFFFF);
        chk("t2_d_m_dat_m", m_dat_m, 128'hA5A5_0001_0002_0003_0004_0005_0006_5A5A);
        d_dat_m = 128'h7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE;
        #1;
        chk("t2_d_dat_track", m_dat_m, 128'h7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE);
        m_ack = 1'b1;
        #1;
        chk("t2_d_d_ack", d_ack, 1'b1);
        chk("t2_d_if_ack", if_ack, 1'b0);
        @(negedge clk);
        m_ack = 1'b0;
        set_d(1'b0, 1'b0, 12'h000, 128'h0);
        chk("t2_end_m_cyc", m_cyc, 1'b0);
        chk("t2_if_ack_cnt", if_ack_cnt, 2);
        chk("t2_d_ack_cnt", d_ack_cnt, 1);

        // Continuous requests from both masters, 1-cycle ack: I,D,I,D,I,D
        set_i(1'b1, 12'h100);
        set_d(1'b1, 1'b1, 12'h200, 128'h5);
        next_is_d = 1'b0;
        xfers = 0;
        for (int c = 0; c < 40 && xfers < 6; c++) begin
            @(negedge clk);
            m_ack = 1'b0;
            if (m_cyc) begin
                chk("rr_grant_adr", m_adr, next_is_d ? 12'h200 : 12'h100);
                m_ack = 1'b1;
                #1;
                chk("rr_if_ack", if_ack, !next_is_d);
                chk("rr_d_ack", d_ack, next_is_d);
                next_is_d = !next_is_d;
                xfers++;
            end
        end
        chk("rr_xfer_count", xfers, 6);
        @(negedge clk);
        m_ack = 1'b0;
        set_i(1'b0, 12'h000);
        set_d(1'b0, 1'b0, 12'h000, 128'h0);
        chk("rr_if_ack_cnt", if_ack_cnt, 5);
        chk("rr_d_ack_cnt", d_ack_cnt, 4);

        // D abort with I pending, then I abort leaves last = D
        set_d(1'b1, 1'b0, 12'h040, 128'h0);
        @(negedge clk);
        chk("t4_d_m_adr", m_adr, 12'h040);
        set_d(1'b0, 1'b0, 12'h040, 128'h0);
        set_i(1'b1, 12'h100);
        @(negedge clk);
        chk("t4_abort_idle", m_cyc, 1'b0);
        @(negedge clk);
        chk("t4_i_next_m_adr", m_adr, 12'h100);
        chk("t4_i_next_m_cyc", m_cyc, 1'b1);
        chk("t4_d_no_ack", d_ack_cnt, 4);
        set_i(1'b0, 12'h100);
        @(negedge clk);
        chk("t4_i_abort_idle", m_cyc, 1'b0);
        set_i(1'b1, 12'h100);
        set_d(1'b1, 1'b0, 12'h040, 128'h0);
        @(negedge clk);
        chk("t4_tie_after_abort", m_adr, 12'h100);
        m_ack = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        set_i(1'b0, 12'h000);
        set_d(1'b0, 1'b0, 12'h000, 128'h0);
        chk("t4_if_ack_cnt", if_ack_cnt, 6);
        chk("t4_d_ack_cnt", d_ack_cnt, 4);

        // Spurious ack in IDLE
        @(negedge clk);
        m_ack = 1'b1;
        #1;
        chk("t5_if_ack", if_ack, 1'b0);
        chk("t5_d_ack", d_ack, 1'b0);
        @(negedge clk);
        m_ack = 1'b0;
        chk("t5_still_idle", m_cyc, 1'b0);

        // Reset two cycles into an I transfer (last = I beforehand)
        set_i(1'b1, 12'h100);
        @(negedge clk);
        chk("t6_granted", m_cyc, 1'b1);
        @(negedge clk);
        m_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_m_cyc", m_cyc, 1'b0);
        chk("t6_rst_m_stb", m_stb, 1'b0);
        chk("t6_rst_if_ack", if_ack, 1'b0);
        @(negedge clk);
        m_ack = 1'b0;
        rst_n = 1'b1;
        set_d(1'b1, 1'b0, 12'h040, 128'h0);
        @(negedge clk);
        chk("t6_post_rst_grant", m_adr, 12'h100);
        chk("t6_if_ack_cnt", if_ack_cnt, 6);
        set_i(1'b0, 12'h000);
        set_d(1'b0, 1'b0, 12'h000, 128'h0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
